addsub_arbiter: RTL and testbench

Shares one 5-bit two's-complement add/subtract unit (ripple-carry, C0 selects subtract, E = C5 XOR C4 signed overflow) between two requesters. A round-robin arbiter grants one request at a time. The block latches operands, evaluates the add/subtract in one cycle and holds the result on a single response channel until it is consumed. It sits between the operand sources and the downstream result consumer.

---
 rtl/addsub_arbiter.sv | 124 ++++++++++++
 tb/tb_addsub_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin shared add/subtract unit with held response (ADDSUB_ARB_STATS_EN enables grant counters)
module addsub_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_c,
    output logic             rsp_e,
    output logic [7:0]       grant_cnt0,
    output logic [7:0]       grant_cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nx;
    logic             pri;
    logic [WIDTH-1:0] x_q, y_q;
    logic             sub_q, id_q;
    logic             grant0, grant1;
    logic [WIDTH-1:0] y_inv;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_low;

    // Grant depends only on valids and the pointer, never on operands.
    assign grant0 = req0_valid && (!pri || !req1_valid);
    assign grant1 = req1_valid && (pri || !req0_valid);

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (grant0) begin
                    req0_ready = 1'b1;
                    state_nx   = EXEC;
                end else if (grant1) begin
                    req1_ready = 1'b1;
                    state_nx   = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Low-bit sum exposes the carry into the MSB for the overflow flag.
    always_comb begin
        y_inv    = y_q ^ {WIDTH{sub_q}};
        sum_full = {1'b0, x_q} + {1'b0, y_inv} + {{WIDTH{1'b0}}, sub_q};
        sum_low  = {1'b0, x_q[WIDTH-2:0]} + {1'b0, y_inv[WIDTH-2:0]}
                 + {{(WIDTH-1){1'b0}}, sub_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pri    <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            sub_q  <= 1'b0;
            id_q   <= 1'b0;
            rsp_id <= 1'b0;
            rsp_s  <= '0;
            rsp_c  <= 1'b0;
            rsp_e  <= 1'b0;
        end else begin
            state <= state_nx;
            if (req0_ready) begin
                x_q   <= req0_x;
                y_q   <= req0_y;
                sub_q <= req0_sub;
                id_q  <= 1'b0;
            end else if (req1_ready) begin
                x_q   <= req1_x;
                y_q   <= req1_y;
                sub_q <= req1_sub;
                id_q  <= 1'b1;
            end
            if (state == EXEC) begin
                rsp_id <= id_q;
                rsp_s  <= sum_full[WIDTH-1:0];
                rsp_c  <= sum_full[WIDTH];
                rsp_e  <= sum_full[WIDTH] ^ sum_low[WIDTH-1];
            end
            if (rsp_valid && rsp_ready) pri <= ~rsp_id;
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != 8'hff) grant_cnt0 <= grant_cnt0 + 8'd1;
            if (req1_ready && grant_cnt1 != 8'hff) grant_cnt1 <= grant_cnt1 + 8'd1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_sub;
    logic [4:0] req0_x, req0_y;
    logic       req1_valid, req1_ready, req1_sub;
    logic [4:0] req1_x, req1_y;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_c, rsp_e;
    logic [4:0] rsp_s;
    logic [7:0] grant_cnt0, grant_cnt1;

    typedef struct {
        logic       id;
        logic [4:0] x;
        logic [4:0] y;
        logic       sub;
        logic [4:0] s;
        logic       c;
        logic       e;
    } vec_t;

    typedef struct {
        logic       id;
        logic [4:0] s;
        logic       c;
        logic       e;
    } rsp_t;

    vec_t vecs[9];
    rsp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_e(rsp_e),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic rsp_t model(input logic id, input logic [4:0] x, input logic [4:0] y, input logic sub);
        rsp_t r;
        int xu = int'(x);
        int yu = int'(y);
        int xs = x[4] ? xu - 32 : xu;
        int ys = y[4] ? yu - 32 : yu;
        int ru = sub ? xu - yu : xu + yu;
        int rs = sub ? xs - ys : xs + ys;
        r.id = id;
        r.s  = ru[4:0];
        r.c  = sub ? (xu >= yu) : (xu + yu > 31);
        r.e  = (rs > 15) || (rs < -16);
        return r;
    endfunction

    task automatic drive(input logic id, input logic v, input logic [4:0] x, input logic [4:0] y, input logic sub);
        if (id == 1'b0) begin
            req0_valid = v; req0_x = x; req0_y = y; req0_sub = sub;
        end else begin
            req1_valid = v; req1_x = x; req1_y = y; req1_sub = sub;
        end
    endtask

    task automatic issue(input logic id, input logic [4:0] x, input logic [4:0] y, input logic sub, input rsp_t exp);
        bit got = 0;
        @(negedge clk);
        drive(id, 1'b1, x, y, sub);
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1;
            else @(negedge clk);
        end
        check("accept", 32'(got), 32'd1);
        if (got) begin
            sbq.push_back(exp);
            @(posedge clk);
            #1;
        end
        drive(id, 1'b0, x, y, sub);
    endtask

    task automatic collect(input bit chk_lat);
        bit   found = 0;
        int   n = 0;
        rsp_t e;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid) found = 1;
        end
        check("rsp_seen", 32'(found), 32'd1);
        if (found) begin
            if (chk_lat) check("latency", 32'(n), 32'd2);
            check("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_s", 32'(rsp_s), 32'(e.s));
                check("rsp_c", 32'(rsp_c), 32'(e.c));
                check("rsp_e", 32'(rsp_e), 32'(e.e));
            end
            check("ready_in_resp", 32'({req0_ready, req1_ready}), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit   got;
        bit   seen;
        logic gid;
        rsp_t e;

        vecs[0] = '{1'b0, 5'd7,  5'd5,  1'b0, 5'd12, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'd15, 5'd3,  1'b1, 5'd12, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 5'd15, 5'd1,  1'b0, 5'd16, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5'd3,  5'd5,  1'b1, 5'd30, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0};
        vecs[5] = '{1'b1, 5'd16, 5'd1,  1'b1, 5'd15, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 5'd31, 5'd1,  1'b0, 5'd0,  1'b1, 1'b0};
        vecs[7] = '{1'b1, 5'd16, 5'd16, 1'b0, 5'd0,  1'b1, 1'b1};
        vecs[8] = '{1'b0, 5'd15, 5'd15, 1'b0, 5'd30, 1'b0, 1'b1};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", 32'({rsp_id, rsp_s, rsp_c, rsp_e}), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_cnt", 32'({grant_cnt0, grant_cnt1}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            e = '{vecs[i].id, vecs[i].s, vecs[i].c, vecs[i].e};
            issue(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].sub, e);
            collect(1'b1);
        end

        // Arbitration: both valid from reset, held across four operations.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(1'b0, 1'b1, 5'd1, 5'd1, 1'b0);
        drive(1'b1, 1'b1, 5'd2, 5'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            got = 0;
            gid = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    got = 1;
                    gid = req1_ready;
                end else @(negedge clk);
            end
            check("arb_accept", 32'(got), 32'd1);
            if (got) begin
                check("grant_order", 32'(gid), 32'(k % 2));
                sbq.push_back(gid ? model(1'b1, 5'd2, 5'd3, 1'b1) : model(1'b0, 5'd1, 5'd1, 1'b0));
                @(posedge clk);
                #1;
                collect(1'b0);
            end
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
`ifdef ADDSUB_ARB_STATS_EN
        check("grant_cnt0", 32'(grant_cnt0), 32'd2);
        check("grant_cnt1", 32'(grant_cnt1), 32'd2);
`else
        check("grant_cnt0_tied", 32'(grant_cnt0), 32'd0);
        check("grant_cnt1_tied", 32'(grant_cnt1), 32'd0);
`endif

        // Backpressure: response held for five cycles, req1 waiting.
        rsp_ready = 1'b0;
        e = model(1'b0, 5'd10, 5'd7, 1'b1);
        issue(1'b0, 5'd10, 5'd7, 1'b1, e);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("bp_rsp_seen", 32'(seen), 32'd1);
        drive(1'b1, 1'b1, 5'd4, 5'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_fields", 32'({rsp_id, rsp_s, rsp_c, rsp_e}), 32'({e.id, e.s, e.c, e.e}));
            check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_consumed", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req1_ready), 32'd1);
        drive(1'b1, 1'b0, 5'd4, 5'd4, 1'b0);
        if (sbq.size() > 0) void'(sbq.pop_front());

        // Reset during EXEC drops the op and restores req0 priority.
        issue(1'b1, 5'd1, 5'd1, 1'b0, model(1'b1, 5'd1, 5'd1, 1'b0));
        rst_n = 1'b0;
        #1;
        check("rst_exec_valid", 32'(rsp_valid), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("dropped_no_rsp", 32'(seen), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd9, 5'd4, 1'b0);
        drive(1'b1, 1'b1, 5'd6, 5'd2, 1'b1);
        #1;
        check("post_rst_pri", 32'({req0_ready, req1_ready}), 32'b10);
        sbq.push_back(model(1'b0, 5'd9, 5'd4, 1'b0));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        collect(1'b1);

`ifdef ADDSUB_ARB_STATS_EN
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 258; i++) begin
            issue(1'b0, 5'(i), 5'd3, 1'(i % 2), model(1'b0, 5'(i), 5'd3, 1'(i % 2)));
            collect(1'b0);
        end
        check("cnt0_saturate", 32'(grant_cnt0), 32'd255);
        check("cnt1_idle", 32'(grant_cnt1), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
